mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, word address width of the shared RAM.
REQ-002 SHALL have parameter DATA_W, default 32, RAM word width.
REQ-003 SHALL have parameter MAX_D_STREAK, default 2, the number of consecutive data grants after which a pending fetch wins.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 if_req / if_addr  input  1 / ADDR_W  fetch read request and word address.
REQ-007 if_flush  input  1  cancels any in-flight fetch read (branch squash).
REQ-008 if_gnt / if_rvalid / if_rdata  output  1 / 1 / DATA_W  fetch grant, read-data valid strobe and read data.
REQ-009 d_req / d_we / d_addr / d_wdata  input  1 / 1 / ADDR_W / DATA_W  data-port request, write enable, address and write data.
REQ-010 d_gnt / d_rvalid / d_rdata  output  1 / 1 / DATA_W  data grant, load-data valid strobe and load data.
REQ-011 mem_addr / mem_wren / mem_wdata  output  ADDR_W / 1 / DATA_W  drive for a single-port RAM with registered address and unregistered q.
REQ-012 mem_q  input  DATA_W  RAM read data, valid in the cycle after the address edge.
REQ-013 busy  output  1  high while a read is outstanding.

Function
REQ-014 FSM states SHALL be IDLE, RD_WAIT and RD_DONE.
REQ-015 Grants SHALL be issued only in IDLE or RD_DONE, combinationally from the current-cycle requests, with at most one grant per cycle.
REQ-016 When both ports request, data SHALL win unless d_streak == MAX_D_STREAK, in which case fetch wins.
REQ-017 d_streak SHALL increment on each data grant made while if_req is high, clear on any fetch grant, and clear on any cycle with if_req low.
REQ-018 In a granted cycle, mem_addr SHALL equal the winner's address, and mem_wren = d_gnt & d_we with mem_wdata = d_wdata.
REQ-019 In non-granted cycles, mem_wren SHALL be 0 and mem_addr SHALL hold its last granted value.
REQ-020 A granted write SHALL complete in one cycle, produce no rvalid, and keep the FSM in IDLE (back-to-back writes allowed).
REQ-021 A granted read SHALL move the FSM to RD_WAIT and record its owner (fetch or data).
REQ-022 RD_WAIT SHALL register mem_q into the owner's rdata register and go to RD_DONE.
REQ-023 In RD_DONE the owner's rvalid SHALL be high for exactly one cycle.
REQ-024 Read latency SHALL be 2 cycles from grant to rvalid, giving a peak read throughput of 1 per 2 cycles.
REQ-025 RD_DONE SHALL transition to RD_WAIT on a new read grant, otherwise to IDLE.
REQ-026 if_flush high while a fetch read is in RD_WAIT or RD_DONE SHALL force if_rvalid low for that read; the data path SHALL be unaffected.
REQ-027 if_flush high in IDLE SHALL suppress if_gnt in that cycle.
REQ-028 Requesters SHALL hold req, addr and wdata stable until gnt; the arbiter SHALL NOT latch a request that is not granted.
REQ-029 if_rdata and d_rdata SHALL hold their value until the next read completes for that port.
REQ-030 busy SHALL be 1 exactly in RD_WAIT.

Reset
REQ-031 With rst_n low at a rising edge, the next state SHALL be: FSM = IDLE, d_streak = 0, owner = fetch, rvalids = 0, rdata registers = 0, mem_addr = 0.
REQ-032 While rst_n is low, gnts and mem_wren SHALL be 0 combinationally.
REQ-033 Reset during RD_WAIT or RD_DONE SHALL discard the outstanding read, with no rvalid afterward.

Structure
REQ-034 Package cpu_mem_pkg SHALL hold the FSM state enum, the owner enum, and the ADDR_W / DATA_W defaults.
REQ-035 Priority and streak selection SHALL be one combinational sub-module, mem_arb_pick; the FSM and registers SHALL stay in the top module.

Verification
REQ-036 Scenario: RAM word 5 = 0x0000_0ABC; fetch read addr 5 -> if_gnt at cycle 0; if_rvalid = 1 with if_rdata = 0x0000_0ABC at cycle 2 only.
REQ-037 Scenario: data write addr 29 wdata 8, then data read addr 29 next cycle -> write in cycle 0, read granted cycle 1, d_rvalid with d_rdata = 8 at cycle 3.
REQ-038 Scenario: if_req and d_req (reads) held continuously -> grant order D, D, F, D, D, F.
REQ-039 Scenario: if_flush pulsed in RD_WAIT of a fetch read -> no if_rvalid; a data read granted in that RD_DONE still returns normally.
REQ-040 Scenario: rst_n low for one edge during RD_WAIT -> IDLE next cycle, no rvalid, and a fresh read of addr 10 returns the correct data 2 cycles after grant.
REQ-041 Scenario: d_req write held with if_req low for 4 cycles -> 4 writes in 4 consecutive cycles, d_streak stays 0, busy stays 0.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared types and default widths for the fetch/data memory port arbiter.
package cpu_mem_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } rd_owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational fetch/data priority pick with data-streak fairness.
module mem_arb_pick #(
  parameter int MAX_D_STREAK = 2,
  parameter int STREAK_W     = 2
) (
  input  logic                en_i,
  input  logic                if_req_i,
  input  logic                if_block_i,
  input  logic                d_req_i,
  input  logic [STREAK_W-1:0] streak_i,
  output logic                if_gnt_o,
  output logic                d_gnt_o,
  output logic [STREAK_W-1:0] streak_d_o
);

  logic fetch_ok;
  logic data_ok;
  logic streak_full;

  always_comb begin
    fetch_ok    = en_i & if_req_i & ~if_block_i;
    data_ok     = en_i & d_req_i;
    streak_full = (streak_i >= STREAK_W'(MAX_D_STREAK));
    if_gnt_o    = 1'b0;
    d_gnt_o     = 1'b0;
    if (fetch_ok && data_ok) begin
      if_gnt_o = streak_full;
      d_gnt_o  = ~streak_full;
    end else begin
      if_gnt_o = fetch_ok;
      d_gnt_o  = data_ok;
    end

    // Streak saturates so a flush-suppressed fetch cannot wrap the counter.
    streak_d_o = streak_i;
    if (!if_req_i || if_gnt_o) begin
      streak_d_o = '0;
    end else if (d_gnt_o && !streak_full) begin
      streak_d_o = streak_i + STREAK_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data ports onto one single-port RAM (registered address, 2-cycle reads).
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MAX_D_STREAK = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy
);

  localparam int STREAK_W = $clog2(MAX_D_STREAK + 2);

  arb_state_e          state_q, state_d;
  rd_owner_e           owner_q, owner_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                squash_q, squash_d;

  logic              can_grant;
  logic              if_block;
  logic              any_gnt;
  logic              rd_gnt;
  logic [ADDR_W-1:0] win_addr;

  assign can_grant = rst_n & (state_q != RD_WAIT);
  assign if_block  = if_flush & (state_q == IDLE);

  mem_arb_pick #(
    .MAX_D_STREAK(MAX_D_STREAK),
    .STREAK_W    (STREAK_W)
  ) u_pick (
    .en_i      (can_grant),
    .if_req_i  (if_req),
    .if_block_i(if_block),
    .d_req_i   (d_req),
    .streak_i  (streak_q),
    .if_gnt_o  (if_gnt),
    .d_gnt_o   (d_gnt),
    .streak_d_o(streak_d)
  );

  assign any_gnt  = if_gnt | d_gnt;
  assign rd_gnt   = if_gnt | (d_gnt & ~d_we);
  assign win_addr = if_gnt ? if_addr : d_addr;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    squash_d   = squash_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    addr_d     = any_gnt ? win_addr : addr_q;
    case (state_q)
      IDLE, RD_DONE: begin
        if (rd_gnt) begin
          state_d  = RD_WAIT;
          owner_d  = if_gnt ? OWN_FETCH : OWN_DATA;
          squash_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        state_d = RD_DONE;
        // A squashed fetch keeps the previous if_rdata; the read never completes.
        if (owner_q == OWN_DATA) begin
          d_rdata_d = mem_q;
        end else if (if_flush) begin
          squash_d = 1'b1;
        end else begin
          if_rdata_d = mem_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= OWN_FETCH;
      streak_q   <= '0;
      addr_q     <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      squash_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      streak_q   <= streak_d;
      addr_q     <= addr_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      squash_q   <= squash_d;
    end
  end

  assign mem_addr  = any_gnt ? win_addr : addr_q;
  assign mem_wren  = d_gnt & d_we;
  assign mem_wdata = d_wdata;
  assign busy      = (state_q == RD_WAIT);
  assign if_rvalid = (state_q == RD_DONE) & (owner_q == OWN_FETCH) & ~squash_q & ~if_flush;
  assign d_rvalid  = (state_q == RD_DONE) & (owner_q == OWN_DATA);
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus constrained-random traffic against a transaction-level arbiter model.
module tb_mem_port_arbiter;

  localparam int AW    = 11;
  localparam int DW    = 32;
  localparam int MAXS  = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_flush;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_wren;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_q;
  logic          busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .MAX_D_STREAK(MAXS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_flush (if_flush),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .mem_addr (mem_addr),
    .mem_wren (mem_wren),
    .mem_wdata(mem_wdata),
    .mem_q    (mem_q),
    .busy     (busy)
  );

  // Unwritten RAM words read back a fixed address-derived pattern; word 5 holds 0xABC.
  function automatic logic [DW-1:0] initVal(input logic [AW-1:0] a);
    if (a == AW'(5)) return 32'h0000_0ABC;
    return {a, a, a[9:0]} ^ 32'hA5A5_0000;
  endfunction

  logic [DW-1:0] ram [0:DEPTH-1];
  bit            ramWritten [0:DEPTH-1];
  logic [AW-1:0] ramRaddr;

  // Single-port RAM with a registered address and an unregistered read port.
  always @(posedge clk) begin
    if (mem_wren) begin
      ram[mem_addr]        <= mem_wdata;
      ramWritten[mem_addr] <= 1'b1;
    end
    ramRaddr <= mem_addr;
  end

  assign mem_q = ramWritten[ramRaddr] ? ram[ramRaddr] : initVal(ramRaddr);

  // Reference model: a read granted in cycle g returns in cycle g+2, and nothing
  // may be granted in cycle g+1; a reset in between discards the read.
  logic [DW-1:0] modelMem [0:DEPTH-1];
  bit            modelWritten [0:DEPTH-1];
  int            cyc = 0;
  int            lastReadGrant = -10;
  bit            rdOwnerData = 1'b0;
  bit            rdSquashed = 1'b0;
  logic [DW-1:0] rdExpData = '0;
  int            streak = 0;
  logic [AW-1:0] lastAddr = '0;
  bit            lastIfGnt;
  bit            lastDGnt;
  string         gntLog = "";
  int            checks = 0;
  int            errors = 0;

  function automatic logic [DW-1:0] modelRead(input logic [AW-1:0] a);
    return modelWritten[a] ? modelMem[a] : initVal(a);
  endfunction

  // Every comparison flows through here so the counters stay in one place.
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // Drive one cycle of inputs shortly after the rising edge.
  task automatic applyStimulus(input bit rstIn, input bit ifReqIn, input logic [AW-1:0] ifAddrIn,
                               input bit flushIn, input bit dReqIn, input bit dWeIn,
                               input logic [AW-1:0] dAddrIn, input logic [DW-1:0] dWdataIn);
    @(posedge clk);
    #1;
    rst_n    = rstIn;
    if_req   = ifReqIn;
    if_addr  = ifAddrIn;
    if_flush = flushIn;
    d_req    = dReqIn;
    d_we     = dWeIn;
    d_addr   = dAddrIn;
    d_wdata  = dWdataIn;
  endtask

  // Compare all outputs at the falling edge, then advance the model across the next rising edge.
  task automatic checkOutput();
    bit            inWait, inDone, idleSt, fetchOk, expIf, expD, expIfValid;
    logic [AW-1:0] expAddr;
    @(negedge clk);
    inWait = (lastReadGrant == cyc - 1);
    inDone = (lastReadGrant == cyc - 2);
    idleSt = !inWait && !inDone;
    expIf  = 1'b0;
    expD   = 1'b0;
    if (rst_n && !inWait) begin
      fetchOk = if_req && !(if_flush && idleSt);
      if (fetchOk && d_req) begin
        if (streak >= MAXS) expIf = 1'b1;
        else expD = 1'b1;
      end else begin
        expIf = fetchOk;
        expD  = d_req;
      end
    end
    expAddr    = expIf ? if_addr : (expD ? d_addr : lastAddr);
    expIfValid = inDone && !rdOwnerData && !rdSquashed && !if_flush;

    chk("if_gnt", 32'(if_gnt), 32'(expIf));
    chk("d_gnt", 32'(d_gnt), 32'(expD));
    chk("mem_wren", 32'(mem_wren), 32'(expD && d_we));
    chk("mem_addr", 32'(mem_addr), 32'(expAddr));
    if (expD && d_we) chk("mem_wdata", mem_wdata, d_wdata);
    chk("busy", 32'(busy), 32'(inWait));
    chk("if_rvalid", 32'(if_rvalid), 32'(expIfValid));
    chk("d_rvalid", 32'(d_rvalid), 32'(inDone && rdOwnerData));
    if (inDone && rdOwnerData) chk("d_rdata", d_rdata, rdExpData);
    if (expIfValid) chk("if_rdata", if_rdata, rdExpData);

    if (if_gnt) gntLog = {gntLog, "F"};
    if (d_gnt) gntLog = {gntLog, "D"};
    if (inWait && !rdOwnerData && if_flush) rdSquashed = 1'b1;

    lastIfGnt = expIf;
    lastDGnt  = expD;
    if (!rst_n) begin
      lastReadGrant = -10;
      streak        = 0;
      lastAddr      = '0;
      rdSquashed    = 1'b0;
    end else begin
      if (expIf || expD) lastAddr = expAddr;
      if (!if_req || expIf) streak = 0;
      else if (expD) streak = (streak < MAXS) ? streak + 1 : MAXS;
      if (expD && d_we) begin
        modelMem[d_addr]     = d_wdata;
        modelWritten[d_addr] = 1'b1;
      end else if (expIf || expD) begin
        lastReadGrant = cyc;
        rdOwnerData   = expD;
        rdExpData     = modelRead(expAddr);
        rdSquashed    = 1'b0;
      end
    end
    cyc++;
  endtask

  bit            fPend, dPend, dWeR, flushR, rstR;
  logic [AW-1:0] fAddrR, dAddrR;
  logic [DW-1:0] dWdataR;
  int            dGntCount;

  initial begin
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

    $display("[TB] reset");
    repeat (2) begin applyStimulus(0, 0, 0, 0, 0, 0, 0, 0); checkOutput(); end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0); checkOutput();
    chk("rst_if_rdata", if_rdata, '0);
    chk("rst_d_rdata", d_rdata, '0);

    $display("[TB] fetch read of word 5");
    applyStimulus(1, 1, 5, 0, 0, 0, 0, 0); checkOutput();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0); checkOutput();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0); checkOutput();
    chk("s36_if_rvalid", 32'(if_rvalid), 32'(1));
    chk("s36_if_rdata", if_rdata, 32'h0000_0ABC);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0); checkOutput();
    chk("s36_if_rdata_hold", if_rdata, 32'h0000_0ABC);

    $display("[TB] data write then read of word 29");
    applyStimulus(1, 0, 0, 0, 1, 1, 29, 8); checkOutput();
    applyStimulus(1, 0, 0, 0, 1, 0, 29, 0); checkOutput();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0); checkOutput();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0); checkOutput();
    chk("s37_d_rvalid", 32'(d_rvalid), 32'(1));
    chk("s37_d_rdata", d_rdata, 32'd8);

    $display("[TB] contention fairness");
    gntLog = "";
    repeat (12) begin applyStimulus(1, 1, 5, 0, 1, 0, 29, 0); checkOutput(); end
    checks++;
    assert (gntLog == "DDFDDF")
    else begin
      errors++;
      $error("[TB] FAIL grant_order: observed %s expected DDFDDF", gntLog);
    end
    repeat (2) begin applyStimulus(1, 0, 0, 0, 0, 0, 0, 0); checkOutput(); end

    $display("[TB] flush during fetch read");
    applyStimulus(1, 1, 5, 0, 0, 0, 0, 0); checkOutput();
    applyStimulus(1, 0, 0, 1, 1, 0, 29, 0); checkOutput();
    applyStimulus(1, 0, 0, 0, 1, 0, 29, 0); checkOutput();
    chk("s39_if_rvalid", 32'(if_rvalid), 32'(0));
    chk("s39_d_gnt", 32'(d_gnt), 32'(1));
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0); checkOutput();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0); checkOutput();
    chk("s39_d_rdata", d_rdata, 32'd8);

    $display("[TB] reset during read wait");
    applyStimulus(1, 1, 7, 0, 0, 0, 0, 0); checkOutput();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0); checkOutput();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0); checkOutput();
    chk("s40_no_rvalid", 32'(if_rvalid), 32'(0));
    applyStimulus(1, 1, 10, 0, 0, 0, 0, 0); checkOutput();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0); checkOutput();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0); checkOutput();
    chk("s40_if_rdata", if_rdata, initVal(AW'(10)));

    $display("[TB] back-to-back writes");
    dGntCount = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 0, 0, 1, 1, AW'(40 + i), DW'(100 + i)); checkOutput();
      if (d_gnt && !busy) dGntCount++;
    end
    chk("s41_write_count", 32'(dGntCount), 32'd4);

    $display("[TB] random traffic");
    fPend = 1'b0; dPend = 1'b0; fAddrR = '0; dAddrR = '0; dWeR = 1'b0; dWdataR = '0;
    for (int n = 0; n < 600; n++) begin
      if (!fPend && $urandom_range(0, 9) < 5) begin
        fPend  = 1'b1;
        fAddrR = AW'($urandom_range(0, 47));
      end
      if (!dPend && $urandom_range(0, 9) < 6) begin
        dPend   = 1'b1;
        dWeR    = ($urandom_range(0, 1) == 1);
        dAddrR  = AW'($urandom_range(0, 47));
        dWdataR = $urandom;
      end
      flushR = ($urandom_range(0, 9) == 0);
      rstR   = ($urandom_range(0, 49) != 0);
      applyStimulus(rstR, fPend, fAddrR, flushR, dPend, dWeR, dAddrR, dWdataR);
      checkOutput();
      if (lastIfGnt) fPend = 1'b0;
      if (lastDGnt) dPend = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
